// File: rtl/sram_resp_pkg.sv
// -----------------------------------------------------------------------------
// sram_resp_pkg
// Shared types and constants for the SRAM bus responder.
//   resp_state_t : responder FSM state (IDLE, RD_WAIT, RD_DRIVE)
//   DATA_W       : width of the bidirectional data bus
//   BUS_ADDR_W   : width of the bus word address
//   bus_decode   : turns the active-low strobes into {read, write}
// -----------------------------------------------------------------------------
package sram_resp_pkg;

    localparam int DATA_W     = 16;
    localparam int BUS_ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } resp_state_t;

    // WE low wins over OE low, so a read needs WE high.
    function automatic logic [1:0] bus_decode(input logic ce, input logic oe,
                                              input logic we);
        logic rd;
        logic wr;
        rd = ~ce & ~oe & we;
        wr = ~ce & ~we;
        return {rd, wr};
    endfunction

endpackage

// File: rtl/sram_resp_array.sv
// -----------------------------------------------------------------------------
// sram_resp_array
// Single-port RAM with a synchronous read and per-byte write enables.
// The addressed word is read on every rising edge, so rdata reflects the
// address presented one edge earlier.
//   Clk   : clock
//   addr  : word address
//   we    : write strobe (byte lanes further qualified by be)
//   be    : {upper, lower} byte-lane enables, active high
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module sram_resp_array
    import sram_resp_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 Clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  logic [1:0]           be,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge Clk) begin
        if (we) begin
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_bus_responder.sv
// -----------------------------------------------------------------------------
// sram_bus_responder
// Stands in for the external asynchronous SRAM of the SLC-3: serves CPU reads
// with a fixed latency, commits writes with zero wait states, and accepts a
// preload stream while the bus is deselected.
//   Clk, Reset    : clock, asynchronous active-low reset
//   CE,OE,WE      : active-low chip/output/write enables (WE dominates OE)
//   UB,LB         : active-low byte-lane enables
//   ADDR          : 20-bit word address (bits above ADDR_BITS must be zero)
//   Data          : bidirectional data, driven here only for reads
//   load_*        : valid/ready preload port
//   busy          : FSM not in IDLE
//   err_oor       : sticky out-of-range access flag
//   dbg_state     : current FSM state
//
// Handshake: a preload word transfers on a rising edge where load_valid and
// load_ready are both high; load_valid may be held without load_ready and
// load_addr/load_data must stay stable until the transfer. load_ready is only
// offered while the FSM is IDLE and the chip is deselected, so a bus access
// and a preload never share the RAM port.
// -----------------------------------------------------------------------------
module sram_bus_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  CE,
    input  logic                  OE,
    input  logic                  WE,
    input  logic                  UB,
    input  logic                  LB,
    input  logic [BUS_ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0]     Data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_BITS-1:0]  load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  busy,
    output logic                  err_oor,
    output resp_state_t           dbg_state
);

    // The counter is loaded so RD_DRIVE is entered READ_LATENCY-1 edges after
    // the read is sampled; drive_q rises on the following edge, which puts
    // valid data on the bus READ_LATENCY edges after the read was sampled.
    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    logic rd;
    logic wr;
    logic oor;
    logic addr_chg;
    logic load_xfer;

    resp_state_t           state;
    logic [3:0]            cnt;
    logic [BUS_ADDR_W-1:0] addr_q;
    logic                  oor_q;
    logic                  drive_q;

    logic                  mem_we;
    logic [1:0]            mem_be;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic [DATA_W-1:0]     dout;

    assign {rd, wr}   = bus_decode(CE, OE, WE);
    assign oor        = |ADDR[BUS_ADDR_W-1:ADDR_BITS];
    assign addr_chg   = (ADDR != addr_q);
    assign load_ready = (state == IDLE) & CE & Reset;
    assign load_xfer  = load_valid & load_ready;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    // RAM port arbitration: bus write, else preload, else keep reading the
    // latched read address.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 2'b11;
        mem_addr  = addr_q[ADDR_BITS-1:0];
        mem_wdata = load_data;
        if (wr) begin
            mem_we    = ~oor;
            mem_be    = {~UB, ~LB};
            mem_addr  = ADDR[ADDR_BITS-1:0];
            mem_wdata = Data;
        end else if (load_xfer) begin
            mem_we    = 1'b1;
            mem_addr  = load_addr;
        end
    end

    sram_resp_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .Clk   (Clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            drive_q <= 1'b0;
            err_oor <= 1'b0;
        end else begin
            if ((rd | wr) & oor) err_oor <= 1'b1;

            if (wr) begin
                // A write aborts any read in progress.
                state   <= IDLE;
                cnt     <= 4'd0;
                drive_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rd) begin
                            addr_q <= ADDR;
                            oor_q  <= oor;
                            cnt    <= CNT_LOAD;
                            state  <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (!rd) begin
                            state <= IDLE;
                            cnt   <= 4'd0;
                        end else if (addr_chg) begin
                            addr_q <= ADDR;
                            oor_q  <= oor;
                            cnt    <= CNT_LOAD;
                        end else if (cnt == 4'd1) begin
                            state <= RD_DRIVE;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    RD_DRIVE: begin
                        if (!rd) begin
                            state   <= IDLE;
                            drive_q <= 1'b0;
                        end else if (addr_chg) begin
                            addr_q  <= ADDR;
                            oor_q   <= oor;
                            cnt     <= CNT_LOAD;
                            drive_q <= 1'b0;
                            state   <= RD_WAIT;
                        end else begin
                            drive_q <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        drive_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout = oor_q ? '0 : mem_rdata;

    // Live strobes gate the drivers so the bus is released in the same cycle
    // OE/CE rise or WE falls, without waiting for an edge.
    assign Data[15:8] = (drive_q & rd & ~UB) ? dout[15:8] : 8'hzz;
    assign Data[7:0]  = (drive_q & rd & ~LB) ? dout[7:0]  : 8'hzz;

endmodule
